spi_wrapper: RTL and testbench

SPI_WRAPPER -- requirements
Module: spi_wrapper

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_ram.sv | 93 +++++++++
 rtl/spi_wrapper.sv | 134 +++++++++++++
 tb/tb_spi_wrapper.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave wrapper.
// Holds the slave FSM state type, the frame length and the 2-bit command codes.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } spi_state_e;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    // Bits shifted in per frame after the command-select bit.
    localparam logic [3:0] FRAME_BITS = 4'd10;

endpackage

// File: rtl/spi_ram.sv
// Byte-wide command-driven memory behind the SPI slave.
// Ports: clk, arst (async active-high), din[9:0] + rx_valid (command word in),
//        dout[7:0] + tx_valid (read byte out, tx_valid is a one-cycle pulse).
// Macro SPI_MEM_RESET_EN: when defined, arst clears every memory word to 0x00;
// otherwise the storage array has no reset.
module spi_ram
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADD_SIZE  = 8
) (
    input  logic       clk,
    input  logic       arst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
);

    localparam logic [ADD_SIZE:0] MEM_LIMIT = (ADD_SIZE + 1)'(MEM_DEPTH);

    logic [7:0] mem [MEM_DEPTH];

    logic [ADD_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADD_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [7:0]          dout_q, dout_d;
    logic                tx_valid_q, tx_valid_d;
    logic                wr_en;
    logic                wr_ok;
    logic                rd_ok;
    logic [1:0]          cmd;

    assign cmd   = din[9:8];
    // Addresses past the populated depth are ignored on write, read as zero.
    assign wr_ok = ({1'b0, wr_addr_q} < MEM_LIMIT);
    assign rd_ok = ({1'b0, rd_addr_q} < MEM_LIMIT);

    always_comb begin
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        dout_d     = dout_q;
        tx_valid_d = 1'b0;
        wr_en      = 1'b0;
        if (rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: wr_addr_d = din[ADD_SIZE-1:0];
                CMD_WR_DATA: wr_en = wr_ok;
                CMD_RD_ADDR: rd_addr_d = din[ADD_SIZE-1:0];
                CMD_RD_DATA: begin
                    dout_d     = rd_ok ? mem[rd_addr_q] : 8'h00;
                    tx_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
        end
    end

`ifdef SPI_MEM_RESET_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end
`else
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= din[7:0];
        end
    end
`endif

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// SPI slave front end: frame FSM, 10-bit receive shifter and MISO serialiser
// around the spi_ram command memory (instance RAM).
// Ports: clk, arst (async active-high), SS_n (active-low select), MOSI in,
//        MISO out (registered, LSB-first read data).
// Macro SPI_MEM_RESET_EN (in spi_ram): reset also clears the memory.
module spi_wrapper
    import spi_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ADD_SIZE  = 8
) (
    input  logic clk,
    input  logic arst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO
);

    spi_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [9:0] din_q, din_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rd_flag_q, rd_flag_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [2:0] tx_cnt_q, tx_cnt_d;
    logic       tx_busy_q, tx_busy_d;
    logic       miso_q, miso_d;
    logic [7:0] ram_dout;
    logic       ram_tx_valid;

    spi_ram #(
        .MEM_DEPTH(MEM_DEPTH),
        .ADD_SIZE (ADD_SIZE)
    ) RAM (
        .clk     (clk),
        .arst    (arst),
        .din     (din_q),
        .rx_valid(rx_valid_q),
        .dout    (ram_dout),
        .tx_valid(ram_tx_valid)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        din_d      = din_q;
        rx_valid_d = 1'b0;
        rd_flag_d  = rd_flag_q;
        tx_shift_d = tx_shift_q;
        tx_cnt_d   = tx_cnt_q;
        tx_busy_d  = tx_busy_q;
        miso_d     = 1'b0;

        if (SS_n) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            tx_busy_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d   = CHK_CMD;
                    bit_cnt_d = '0;
                end
                CHK_CMD: begin
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (rd_flag_q) begin
                        state_d = READ_DATA;
                    end else begin
                        state_d = READ_ADD;
                    end
                end
                WRITE, READ_ADD, READ_DATA: begin
                    // Bits beyond the tenth are ignored until SS_n rises.
                    if (bit_cnt_q < FRAME_BITS) begin
                        din_d     = {din_q[8:0], MOSI};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == FRAME_BITS - 4'd1) begin
                            rx_valid_d = 1'b1;
                            if (din_d[9:8] == CMD_RD_ADDR) begin
                                rd_flag_d = 1'b1;
                            end else if (din_d[9:8] == CMD_RD_DATA) begin
                                rd_flag_d = 1'b0;
                            end
                        end
                    end
                    // Load the RAM byte the cycle tx_valid shows, then
                    // emit it LSB first, one bit per clock.
                    if (state_q == READ_DATA) begin
                        if (ram_tx_valid) begin
                            tx_shift_d = ram_dout;
                            tx_cnt_d   = '0;
                            tx_busy_d  = 1'b1;
                        end else if (tx_busy_q) begin
                            miso_d   = tx_shift_q[tx_cnt_q];
                            tx_cnt_d = tx_cnt_q + 3'd1;
                            if (tx_cnt_q == 3'd7) begin
                                tx_busy_d = 1'b0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            din_q      <= '0;
            rx_valid_q <= 1'b0;
            rd_flag_q  <= 1'b0;
            tx_shift_q <= '0;
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            din_q      <= din_d;
            rx_valid_q <= rx_valid_d;
            rd_flag_q  <= rd_flag_d;
            tx_shift_q <= tx_shift_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_busy_q  <= tx_busy_d;
            miso_q     <= miso_d;
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_spi_wrapper.sv
// Self-checking bench for spi_wrapper: directed vector table, hand-written
// reset/abort sequences, and random frames against a behavioural model.
module tb_spi_wrapper;
    import spi_pkg::*;

    localparam int DEPTH = 192;

    logic clk  = 1'b0;
    logic arst = 1'b0;
    logic ss_n = 1'b1;
    logic mosi = 1'b0;
    logic miso;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    spi_wrapper #(
        .MEM_DEPTH(DEPTH),
        .ADD_SIZE (8)
    ) dut (
        .clk (clk),
        .arst(arst),
        .SS_n(ss_n),
        .MOSI(mosi),
        .MISO(miso)
    );

    // Behavioural model: address registers, read flag, byte memory.
    logic [7:0] m_mem [256];
    logic [7:0] m_wr   = 8'h00;
    logic [7:0] m_rd   = 8'h00;
    logic       m_flag = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      name, act, exp, $time);
    endtask

    // Returns the byte the master should see on MISO for this frame.
    function automatic logic [7:0] model_frame(input logic cb,
                                               input logic [9:0] w,
                                               input int nb);
        logic [7:0] r;
        logic       rd_frame;
        r = 8'h00;
        rd_frame = cb && m_flag;
        if (nb >= 10) begin
            case (w[9:8])
                2'b00: m_wr = w[7:0];
                2'b01: if (int'(m_wr) < DEPTH) m_mem[m_wr] = w[7:0];
                2'b10: begin m_rd = w[7:0]; m_flag = 1'b1; end
                default: begin
                    if (rd_frame)
                        r = (int'(m_rd) < DEPTH) ? m_mem[m_rd] : 8'h00;
                    m_flag = 1'b0;
                end
            endcase
        end
        return r;
    endfunction

    task automatic model_reset();
        m_wr = 8'h00;
        m_rd = 8'h00;
        m_flag = 1'b0;
`ifdef SPI_MEM_RESET_EN
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
`endif
    endtask

    // One SPI frame: select bit, nb data bits, then collect the MISO window.
    task automatic run_frame(input logic cb, input logic [9:0] w,
                             input int nb, output logic [7:0] got,
                             output logic stray);
        got = 8'h00;
        stray = 1'b0;
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = cb;
        for (int i = 0; i < nb && i < 10; i++) begin
            @(negedge clk);
            stray |= miso;
            mosi = w[9-i];
        end
        if (nb >= 10) begin
            for (int j = 0; j < 12; j++) begin
                @(negedge clk);
                if (j >= 3 && j <= 10) got[j-3] = miso;
                else stray |= miso;
                mosi = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
        @(negedge clk); stray |= miso;
    endtask

    task automatic frame_chk(input string name, input logic cb,
                             input logic [9:0] w, input int nb);
        logic [7:0] exp, got;
        logic       stray;
        exp = model_frame(cb, w, nb);
        run_frame(cb, w, nb, got, stray);
        chk({name, "_miso"}, 32'(got), 32'(exp));
        chk({name, "_idle0"}, 32'(stray), 32'd0);
    endtask

    typedef struct {
        logic       cb;
        logic [9:0] w;
        int         nb;
        logic [7:0] exp_miso;
        int         mem_addr;
        logic [7:0] exp_mem;
    } vec_t;

    vec_t tbl [12];

    initial begin : main
        logic [7:0] got, addr, dat;
        logic       stray;
        logic [7:0] exp_b;
        int         op;

        tbl[0]  = '{1'b0, 10'b00_1010_1001, 10, 8'h00, -1, 8'h00};
        tbl[1]  = '{1'b0, 10'b01_1111_0001, 10, 8'h00, 169, 8'hF1};
        tbl[2]  = '{1'b1, 10'b10_1010_1001, 10, 8'h00, -1, 8'h00};
        tbl[3]  = '{1'b1, 10'b11_1111_0001, 10, 8'hF1, -1, 8'h00};
        tbl[4]  = '{1'b0, 10'b01_0101_0101, 5, 8'h00, 169, 8'hF1};
        tbl[5]  = '{1'b0, 10'b01_0011_1100, 10, 8'h00, 169, 8'h3C};
        tbl[6]  = '{1'b1, 10'b10_1010_1001, 10, 8'h00, -1, 8'h00};
        tbl[7]  = '{1'b1, 10'b11_0000_0000, 10, 8'h3C, -1, 8'h00};
        tbl[8]  = '{1'b0, 10'b00_1100_1000, 10, 8'h00, -1, 8'h00};
        tbl[9]  = '{1'b0, 10'b01_0111_0111, 10, 8'h00, -1, 8'h00};
        tbl[10] = '{1'b1, 10'b10_1100_1000, 10, 8'h00, -1, 8'h00};
        tbl[11] = '{1'b1, 10'b11_0000_0000, 10, 8'h00, -1, 8'h00};

        // Reset held for three cycles.
        arst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_din", 32'(dut.din_q), 32'd0);
        chk("rst_rxv", 32'(dut.rx_valid_q), 32'd0);
        chk("rst_txv", 32'(dut.RAM.tx_valid_q), 32'd0);
        chk("rst_dout", 32'(dut.RAM.dout_q), 32'd0);
        chk("rst_wra", 32'(dut.RAM.wr_addr_q), 32'd0);
        chk("rst_rda", 32'(dut.RAM.rd_addr_q), 32'd0);
        chk("rst_flag", 32'(dut.rd_flag_q), 32'd0);
        arst = 1'b0;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_frame(tbl[i].cb, tbl[i].w, tbl[i].nb, got, stray);
            void'(model_frame(tbl[i].cb, tbl[i].w, tbl[i].nb));
            chk($sformatf("tbl%0d_miso", i), 32'(got), 32'(tbl[i].exp_miso));
            chk($sformatf("tbl%0d_idle0", i), 32'(stray), 32'd0);
            if (tbl[i].mem_addr >= 0)
                chk($sformatf("tbl%0d_mem", i),
                    32'(dut.RAM.mem[tbl[i].mem_addr]), 32'(tbl[i].exp_mem));
        end

        // Deselected with MOSI high: nothing happens.
        @(negedge clk); ss_n = 1'b1; mosi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ssh_miso", 32'(miso), 32'd0);
        end
        chk("ssh_state", 32'(dut.state_q), 32'(IDLE));
        chk("ssh_mem", 32'(dut.RAM.mem[169]), 32'h3C);
        mosi = 1'b0;

        // Random traffic: seed addresses 0..31, then mixed operations.
        for (int a = 0; a < 32; a++) begin
            frame_chk("init_wa", 1'b0, {2'b00, 8'(a)}, 10);
            frame_chk("init_wd", 1'b0, {2'b01, 8'($urandom)}, 10);
        end
        for (int k = 0; k < 120; k++) begin
            op = int'($urandom_range(0, 3));
            addr = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(192, 255))
                                               : 8'($urandom_range(0, 31));
            dat = 8'($urandom);
            case (op)
                0: frame_chk("rnd_wa", 1'b0, {2'b00, addr}, 10);
                1: begin
                    frame_chk("rnd_wd", 1'b0, {2'b01, dat}, 10);
                    if (int'(m_wr) < DEPTH)
                        chk("rnd_mem", 32'(dut.RAM.mem[m_wr]),
                            32'(m_mem[m_wr]));
                end
                2: begin
                    frame_chk("rnd_ra", 1'b1, {2'b10, addr}, 10);
                    frame_chk("rnd_rd", 1'b1, {2'b11, dat}, 10);
                end
                default: frame_chk("rnd_abort", 1'($urandom_range(0, 1)),
                                   10'($urandom),
                                   int'($urandom_range(0, 9)));
            endcase
        end

        // Reset in the middle of a write-data frame.
        frame_chk("mid_wa", 1'b0, {2'b00, 8'd5}, 10);
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = 1'b0;
        begin
            logic [9:0] wv;
            wv = 10'b01_1010_0101;
            for (int i = 0; i < 7; i++) begin
                @(negedge clk); mosi = wv[9-i];
            end
        end
        #1 arst = 1'b1;
        #1 chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
        @(negedge clk); arst = 1'b0; ss_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("midrst_mem", 32'(dut.RAM.mem[5]), 32'(m_mem[5]));

        // Reset during READ_DATA shift-out.
        frame_chk("sh_ra", 1'b1, {2'b10, 8'd10}, 10);
        exp_b = (int'(m_rd) < DEPTH) ? m_mem[m_rd] : 8'h00;
        @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
        @(negedge clk); mosi = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); mosi = (i < 2) ? 1'b1 : 1'b0;
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (j == 4) chk("sh_bit1", 32'(miso), 32'(exp_b[1]));
        end
        #1 arst = 1'b1;
        #1;
        chk("shrst_miso", 32'(miso), 32'd0);
        chk("shrst_state", 32'(dut.state_q), 32'(IDLE));
        chk("shrst_flag", 32'(dut.rd_flag_q), 32'd0);
        @(negedge clk); arst = 1'b0; ss_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("post_miso", 32'(miso), 32'd0);
        frame_chk("post_ra", 1'b1, {2'b10, 8'd10}, 10);
        frame_chk("post_rd", 1'b1, {2'b11, 8'h00}, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
